// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encodings, frame width and counter width.
// The encodings are shared so the transmit side can use the same state values.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to 1, which is the idle level of a UART line.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised rx line, mid-bit sampling of start, data and stop bits,
// single-cycle strobes for a good byte (out_ready) or a low stop bit (frame_err).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned bd_divider = 2500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       out_ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned half_div = bd_divider / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(bd_divider - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_div - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state, state_nxt;
    logic [CNT_W-1:0]     clk_count, cnt_nxt;
    logic [IDX_W-1:0]     data_index, idx_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [7:0]           dout_nxt;
    logic                 rdy_nxt, err_nxt;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_count  <= '0;
            data_index <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            out_ready  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clk_count  <= cnt_nxt;
            data_index <= idx_nxt;
            shift_reg  <= shift_nxt;
            data_out   <= dout_nxt;
            out_ready  <= rdy_nxt;
            frame_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_count;
        idx_nxt   = data_index;
        shift_nxt = shift_reg;
        dout_nxt  = data_out;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rx_s) state_nxt = START;
            end

            START: begin
                if (clk_count != HALF_LAST) begin
                    cnt_nxt = clk_count + CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                    // A start bit that is high again at its midpoint was a glitch.
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (clk_count != BIT_LAST) begin
                    cnt_nxt = clk_count + CNT_W'(1);
                end else begin
                    cnt_nxt               = '0;
                    shift_nxt[data_index] = rx_s;
                    if (data_index == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = data_index + IDX_W'(1);
                    end
                end
            end

            STOP: begin
                if (clk_count != BIT_LAST) begin
                    cnt_nxt = clk_count + CNT_W'(1);
                end else begin
                    cnt_nxt = '0;
                    // Leaving at the stop midpoint leaves slack for a back-to-back start bit.
                    if (rx_s) begin
                        dout_nxt  = shift_reg;
                        rdy_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                // A held-low line (break) must not be decoded as repeated 0x00 frames.
                if (rx_s) state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with bd_divider=16: scoreboard of expected strobes
// plus per-scenario inline checks.
module tb_uart_rx;

    localparam int BD   = 16;
    localparam int HALF = BD / 2;
    // Edges from driving the start bit to the strobe edge: 2 sync + 1 IDLE + half bit + 9 bits.
    localparam int LAT  = 3 + HALF + 9 * BD;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         exp_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx;
    logic       rx_drv = 1'b1;
    logic       lb_sel = 1'b0;
    logic [7:0] data_out;
    logic       out_ready;
    logic       frame_err;
    logic       busy;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Behavioural transmitter for the loopback scenario.
    logic       tx_go = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_active = 1'b0;
    logic [9:0] tx_sh = '1;
    int         tx_cnt = 0;
    int         tx_bits = 0;
    logic       tx_line;

    assign tx_line = tx_active ? tx_sh[0] : 1'b1;
    assign rx      = lb_sel ? tx_line : rx_drv;

    uart_rx #(.bd_divider(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tx_active) begin
            if (tx_cnt == BD - 1) begin
                tx_cnt  <= 0;
                tx_sh   <= {1'b1, tx_sh[9:1]};
                tx_bits <= tx_bits + 1;
                if (tx_bits == 9) tx_active <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 1;
            end
        end else if (tx_go) begin
            tx_active <= 1'b1;
            tx_sh     <= {1'b1, tx_data, 1'b0};
            tx_cnt    <= 0;
            tx_bits   <= 0;
        end
    end

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (out_ready || frame_err) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: out_ready=%b frame_err=%b data_out=%h at cycle %0d, none expected",
                         out_ready, frame_err, data_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                n_chk++;
                if (frame_err !== mon_e.is_err || out_ready !== !mon_e.is_err) begin
                    n_fail++;
                    $display("FAIL strobe_kind: out_ready=%b frame_err=%b, required frame_err=%b",
                             out_ready, frame_err, mon_e.is_err);
                end
                n_chk++;
                if (data_out !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL strobe_data: data_out=%h, required %h", data_out, mon_e.data);
                end
                n_chk++;
                if (cyc !== mon_e.exp_cyc) begin
                    n_fail++;
                    $display("FAIL strobe_cycle: strobe at cycle %0d, required %0d", cyc, mon_e.exp_cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            tick(BD);
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_t e;
        e.is_err  = 1'b0;
        e.data    = d;
        e.exp_cyc = cyc + LAT;
        sb.push_back(e);
        drive_frame(d, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * BD && sb.size() != 0; i++) tick(1);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d expected strobes never seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rx_drv = 1'b1;
        tick(3);
        n_chk++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, required 00", data_out); end
        n_chk++;
        if (out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_out_ready: got %b, required 0", out_ready); end
        n_chk++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_single();
        send_good(8'hA5);
        drain("single");
        n_chk++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL single_hold: data_out=%h, required a5", data_out); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b, required 0", busy); end
    endtask

    task automatic test_glitch();
        rx_drv = 1'b0;
        tick(4);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: busy=%b, required 1", busy); end
        tick(1);
        rx_drv = 1'b1;
        for (int i = 0; i < 8 && busy; i++) tick(1);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: busy=%b after 8 cycles, required 0", busy); end
        tick(2 * BD);
    endtask

    task automatic test_frame_err();
        exp_t e;
        e.is_err  = 1'b1;
        e.data    = 8'hA5;
        e.exp_cyc = cyc + LAT;
        sb.push_back(e);
        drive_frame(8'h3C, 1'b0);
        tick(40);
        drain("ferr");
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_high: busy=%b while line low, required 1", busy); end
        n_chk++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_hold: data_out=%h, required a5", data_out); end
        rx_drv = 1'b1;
        tick(BD);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release: busy=%b, required 0", busy); end
        send_good(8'h11);
        drain("ferr_next");
        n_chk++;
        if (data_out !== 8'h11) begin n_fail++; $display("FAIL ferr_next_data: data_out=%h, required 11", data_out); end
    endtask

    task automatic test_back_to_back();
        send_good(8'h00);
        send_good(8'hFF);
        drain("b2b");
        n_chk++;
        if (data_out !== 8'hFF) begin n_fail++; $display("FAIL b2b_data: data_out=%h, required ff", data_out); end
    endtask

    task automatic test_reset_midframe();
        logic [3:0] pre;
        pre = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            rx_drv = pre[i];
            tick(BD);
        end
        rx_drv = 1'b0;
        tick(HALF);
        rst_n  = 1'b0;
        rx_drv = 1'b1;
        tick(1);
        n_chk++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL midrst_data_out: got %h, required 00", data_out); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        n_chk++;
        if (out_ready !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_strobes: out_ready=%b frame_err=%b, required 0 0", out_ready, frame_err);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2 * BD);
        send_good(8'h81);
        drain("midrst");
        n_chk++;
        if (data_out !== 8'h81) begin n_fail++; $display("FAIL midrst_fresh: data_out=%h, required 81", data_out); end
    endtask

    task automatic test_loopback();
        exp_t e;
        lb_sel  = 1'b1;
        tx_data = 8'h55;
        e.is_err  = 1'b0;
        e.data    = 8'h55;
        // The transmitter registers tx_go on the next edge, one cycle after the request.
        e.exp_cyc = cyc + 1 + LAT;
        sb.push_back(e);
        tx_go = 1'b1;
        tick(1);
        tx_go = 1'b0;
        for (int i = 0; i < 12 * BD && tx_active; i++) tick(1);
        n_chk++;
        if (tx_active !== 1'b0) begin n_fail++; $display("FAIL loopback_tx_done: tx still active, required idle"); end
        drain("loopback");
        tick(BD);
        lb_sel = 1'b0;
        n_chk++;
        if (data_out !== 8'h55) begin n_fail++; $display("FAIL loopback_data: data_out=%h, required 55", data_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        tick(BD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
